// File: rtl/alu_pipe_pkg.sv
// Shared definitions for the registered execute-stage ALU: opcodes, flag layout, FSM states.
package alu_pipe_pkg;

    typedef enum logic [3:0] {
        OpAnd = 4'h0, OpEor = 4'h1, OpSub = 4'h2, OpRsb = 4'h3,
        OpAdd = 4'h4, OpAdc = 4'h5, OpSbc = 4'h6, OpRsc = 4'h7,
        OpTst = 4'h8, OpTeq = 4'h9, OpCmp = 4'hA, OpCmn = 4'hB,
        OpOrr = 4'hC, OpMov = 4'hD, OpBic = 4'hE, OpMvn = 4'hF
    } alu_op_e;

    localparam int unsigned FlagC = 3;
    localparam int unsigned FlagN = 2;
    localparam int unsigned FlagZ = 1;
    localparam int unsigned FlagV = 0;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StMul   = 2'd1,
        StFull  = 2'd2
    } state_e;

    // Compare/test opcodes only produce flags; everything else targets Rd.
    function automatic logic op_writes_rd(input alu_op_e op);
        return !(op inside {OpTst, OpTeq, OpCmp, OpCmn});
    endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier retiring MulBits multiplier bits per cycle.
module alu_mul_iter
    import alu_pipe_pkg::*;
#(
    parameter int unsigned Width   = 32,
    parameter int unsigned MulBits = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             start_i,
    input  logic [Width-1:0] a_i,
    input  logic [Width-1:0] b_i,
    input  logic [Width-1:0] acc_i,
    input  logic             acc_en_i,
    output logic             last_o,
    output logic [Width-1:0] product_o
);

    localparam int unsigned Iters = Width / MulBits;
    localparam int unsigned CntW  = (Iters > 1) ? $clog2(Iters) : 1;

    logic             run_q, run_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [Width-1:0] mcand_q, mcand_d;
    logic [Width-1:0] mplier_q, mplier_d;
    logic [Width-1:0] prod_q, prod_d;
    logic [Width-1:0] partial;

    assign last_o    = run_q && (cnt_q == CntW'(Iters - 1));
    assign product_o = prod_q + partial;

    always_comb begin
        partial = '0;
        for (int i = 0; i < int'(MulBits); i++) begin
            if (mplier_q[i]) partial = partial + (mcand_q << i);
        end

        run_d    = run_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        if (start_i) begin
            run_d    = 1'b1;
            cnt_d    = '0;
            mcand_d  = a_i;
            mplier_d = b_i;
            prod_d   = acc_en_i ? acc_i : '0;
        end else if (run_q) begin
            cnt_d    = cnt_q + 1'b1;
            mcand_d  = mcand_q << MulBits;
            mplier_d = mplier_q >> MulBits;
            prod_d   = product_o;
            if (last_o) begin
                run_d = 1'b0;
                cnt_d = '0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            run_q    <= 1'b0;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
        end else begin
            run_q    <= run_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Registered data-processing ALU with iterative MUL/MLA, internal CNZV register and
// valid/ready handshakes on both sides.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MUL_BITS = 2
) (
    input  logic             in_Clk,
    input  logic             in_Rst_n,
    input  logic             in_Valid,
    output logic             out_Ready,
    input  logic [WIDTH-1:0] in_Rn,
    input  logic [WIDTH-1:0] in_Op2,
    input  logic [WIDTH-1:0] in_Acc,
    input  logic             in_Barrel_carry,
    input  logic [3:0]       in_Opcode,
    input  logic             in_Mul,
    input  logic             in_Acc_en,
    input  logic             in_Set_cond,
    input  logic             in_Flag_we,
    input  logic [3:0]       in_Flag_wdata,
    output logic             out_Valid,
    input  logic             in_Ready,
    output logic [WIDTH-1:0] out_Y,
    output logic             out_Writeback,
    output logic [3:0]       out_CNZV,
    output logic             out_Busy
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             wb_q, wb_d;
    logic [3:0]       flags_q, flags_d;
    logic             mul_s_q, mul_s_d;

    alu_op_e          op;
    logic             accept;
    logic             mul_start;
    logic             mul_last;
    logic [WIDTH-1:0] mul_y;

    logic [WIDTH-1:0] add_a, add_b, logic_y, data_y;
    logic             add_cin, arith;
    logic [WIDTH:0]   sum;
    logic [3:0]       data_flags, mul_flags;

    assign op        = alu_op_e'(in_Opcode);
    assign out_Ready = (state_q == StEmpty) || ((state_q == StFull) && in_Ready);
    assign accept    = in_Valid && out_Ready;

    assign out_Valid     = (state_q == StFull);
    assign out_Busy      = (state_q == StMul);
    assign out_Y         = y_q;
    assign out_Writeback = wb_q;
    assign out_CNZV      = flags_q;

    alu_mul_iter #(
        .Width   (WIDTH),
        .MulBits (MUL_BITS)
    ) u_mul (
        .clk_i     (in_Clk),
        .rst_ni    (in_Rst_n),
        .start_i   (mul_start),
        .a_i       (in_Rn),
        .b_i       (in_Op2),
        .acc_i     (in_Acc),
        .acc_en_i  (in_Acc_en),
        .last_o    (mul_last),
        .product_o (mul_y)
    );

    // Subtracts are carried out as a + ~b + cin, so C means "no borrow".
    always_comb begin
        add_a   = in_Rn;
        add_b   = in_Op2;
        add_cin = 1'b0;
        arith   = 1'b1;
        logic_y = '0;
        unique case (op)
            OpAnd, OpTst: begin logic_y = in_Rn & in_Op2;  arith = 1'b0; end
            OpEor, OpTeq: begin logic_y = in_Rn ^ in_Op2;  arith = 1'b0; end
            OpOrr:        begin logic_y = in_Rn | in_Op2;  arith = 1'b0; end
            OpMov:        begin logic_y = in_Op2;          arith = 1'b0; end
            OpBic:        begin logic_y = in_Rn & ~in_Op2; arith = 1'b0; end
            OpMvn:        begin logic_y = ~in_Op2;         arith = 1'b0; end
            OpSub, OpCmp: begin add_b = ~in_Op2; add_cin = 1'b1; end
            OpRsb:        begin add_a = in_Op2; add_b = ~in_Rn; add_cin = 1'b1; end
            OpAdd, OpCmn: ;
            OpAdc:        add_cin = flags_q[FlagC];
            OpSbc:        begin add_b = ~in_Op2; add_cin = flags_q[FlagC]; end
            OpRsc:        begin add_a = in_Op2; add_b = ~in_Rn; add_cin = flags_q[FlagC]; end
        endcase

        sum    = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
        data_y = arith ? sum[WIDTH-1:0] : logic_y;

        data_flags[FlagC] = arith ? sum[WIDTH] : in_Barrel_carry;
        data_flags[FlagN] = data_y[WIDTH-1];
        data_flags[FlagZ] = (data_y == '0);
        data_flags[FlagV] = arith ? ((add_a[WIDTH-1] == add_b[WIDTH-1]) &&
                                     (data_y[WIDTH-1] != add_a[WIDTH-1]))
                                  : flags_q[FlagV];

        mul_flags[FlagC] = flags_q[FlagC];
        mul_flags[FlagN] = mul_y[WIDTH-1];
        mul_flags[FlagZ] = (mul_y == '0);
        mul_flags[FlagV] = flags_q[FlagV];
    end

    // An S-update on the same edge overrides an external flag write.
    always_comb begin
        state_d   = state_q;
        y_d       = y_q;
        wb_d      = wb_q;
        mul_s_d   = mul_s_q;
        mul_start = 1'b0;
        flags_d   = in_Flag_we ? in_Flag_wdata : flags_q;
        unique case (state_q)
            StEmpty, StFull: begin
                if ((state_q == StFull) && in_Ready) state_d = StEmpty;
                if (accept) begin
                    if (in_Mul) begin
                        state_d   = StMul;
                        mul_start = 1'b1;
                        mul_s_d   = in_Set_cond;
                    end else begin
                        state_d = StFull;
                        y_d     = data_y;
                        wb_d    = op_writes_rd(op);
                        if (in_Set_cond) flags_d = data_flags;
                    end
                end
            end
            StMul: begin
                if (mul_last) begin
                    state_d = StFull;
                    y_d     = mul_y;
                    wb_d    = 1'b1;
                    if (mul_s_q) flags_d = mul_flags;
                end
            end
            default: state_d = StEmpty;
        endcase
    end

    always_ff @(posedge in_Clk or negedge in_Rst_n) begin
        if (!in_Rst_n) begin
            state_q <= StEmpty;
            y_q     <= '0;
            wb_q    <= 1'b0;
            flags_q <= '0;
            mul_s_q <= 1'b0;
        end else begin
            state_q <= state_d;
            y_q     <= y_d;
            wb_q    <= wb_d;
            flags_q <= flags_d;
            mul_s_q <= mul_s_d;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed and randomized bench for alu_pipe against an arithmetic reference model.
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_Valid, out_Ready, in_Barrel_carry, in_Mul, in_Acc_en, in_Set_cond;
    logic        in_Flag_we, out_Valid, in_Ready, out_Writeback, out_Busy;
    logic [31:0] in_Rn, in_Op2, in_Acc, out_Y;
    logic [3:0]  in_Opcode, in_Flag_wdata, out_CNZV;

    always #5 clk = ~clk;

    alu_pipe #(
        .WIDTH    (32),
        .MUL_BITS (2)
    ) dut (
        .in_Clk          (clk),
        .in_Rst_n        (rst_n),
        .in_Valid        (in_Valid),
        .out_Ready       (out_Ready),
        .in_Rn           (in_Rn),
        .in_Op2          (in_Op2),
        .in_Acc          (in_Acc),
        .in_Barrel_carry (in_Barrel_carry),
        .in_Opcode       (in_Opcode),
        .in_Mul          (in_Mul),
        .in_Acc_en       (in_Acc_en),
        .in_Set_cond     (in_Set_cond),
        .in_Flag_we      (in_Flag_we),
        .in_Flag_wdata   (in_Flag_wdata),
        .out_Valid       (out_Valid),
        .in_Ready        (in_Ready),
        .out_Y           (out_Y),
        .out_Writeback   (out_Writeback),
        .out_CNZV        (out_CNZV),
        .out_Busy        (out_Busy)
    );

    typedef struct packed {
        logic [31:0] y;
        logic        wb;
    } exp_t;

    exp_t       expq[$];
    int         checks = 0;
    int         errors = 0;
    logic [3:0] mflags;
    bit         rdy_rand;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: plain integer arithmetic on 64-bit values.
    function automatic void model(input logic [3:0] op, input logic [31:0] rn,
                                  input logic [31:0] op2, input logic bc, input logic [3:0] fin,
                                  output logic [31:0] y, output logic [3:0] fo, output logic wb);
        longint unsigned ur, uo, ures, cin, bw;
        longint          sr, so, sres;
        logic            cf;
        bit              arith;
        ur = 64'(rn);
        uo = 64'(op2);
        sr = longint'($signed(rn));
        so = longint'($signed(op2));
        cin = fin[3] ? 64'd1 : 64'd0;
        bw  = fin[3] ? 64'd0 : 64'd1;
        ures = 0; sres = 0; cf = 1'b0; arith = 1'b1; y = '0;
        case (op)
            4'h0, 4'h8: begin y = rn & op2; arith = 1'b0; end
            4'h1, 4'h9: begin y = rn ^ op2; arith = 1'b0; end
            4'h2, 4'hA: begin ures = ur - uo; sres = sr - so; cf = (ur >= uo); end
            4'h3:       begin ures = uo - ur; sres = so - sr; cf = (uo >= ur); end
            4'h4, 4'hB: begin ures = ur + uo; sres = sr + so; cf = ures[32]; end
            4'h5:       begin ures = ur + uo + cin; sres = sr + so + longint'(cin); cf = ures[32]; end
            4'h6:       begin ures = ur - uo - bw; sres = sr - so - longint'(bw); cf = (ur >= uo + bw); end
            4'h7:       begin ures = uo - ur - bw; sres = so - sr - longint'(bw); cf = (uo >= ur + bw); end
            4'hC:       begin y = rn | op2;  arith = 1'b0; end
            4'hD:       begin y = op2;       arith = 1'b0; end
            4'hE:       begin y = rn & ~op2; arith = 1'b0; end
            default:    begin y = ~op2;      arith = 1'b0; end
        endcase
        if (arith) y = ures[31:0];
        fo[3] = arith ? cf : bc;
        fo[2] = y[31];
        fo[1] = (y == 32'd0);
        fo[0] = arith ? ((sres > 64'sd2147483647) || (sres < -64'sd2147483648)) : fin[0];
        wb = (op < 4'h8) || (op > 4'hB);
    endfunction

    // One clock: check any result handed over and model any acceptance on the coming edge.
    task automatic cycle(output bit acc);
        exp_t        e;
        logic [31:0] my;
        logic [3:0]  mf;
        logic        mwb;
        bit          s_upd;
        if (rdy_rand) in_Ready = 1'($urandom_range(0, 1));
        #1;
        acc = in_Valid && out_Ready;
        if (out_Valid && in_Ready) begin
            chk("spurious_result", 64'(expq.size() == 0), 64'd0);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                chk("result_y", 64'(out_Y), 64'(e.y));
                chk("result_wb", 64'(out_Writeback), 64'(e.wb));
            end
        end
        s_upd = 1'b0;
        if (acc) begin
            chk("flags_at_accept", 64'(out_CNZV), 64'(mflags));
            if (in_Mul) begin
                my  = 32'(longint'(in_Rn) * longint'(in_Op2) +
                          (in_Acc_en ? longint'(in_Acc) : 64'sd0));
                mwb = 1'b1;
                if (in_Set_cond) begin
                    mflags = {mflags[3], my[31], my == 32'd0, mflags[0]};
                    s_upd  = 1'b1;
                end
            end else begin
                model(in_Opcode, in_Rn, in_Op2, in_Barrel_carry, mflags, my, mf, mwb);
                if (in_Set_cond) begin
                    mflags = mf;
                    s_upd  = 1'b1;
                end
            end
            e.y  = my;
            e.wb = mwb;
            expq.push_back(e);
        end
        if (in_Flag_we && !s_upd) mflags = in_Flag_wdata;
        @(negedge clk);
    endtask

    task automatic issue(input logic mul, input logic acc_en, input logic s, input logic [3:0] op,
                         input logic [31:0] rn, input logic [31:0] op2, input logic [31:0] acc,
                         input logic bc, input logic fwe, input logic [3:0] fwd,
                         output int waits);
        bit a;
        in_Valid = 1'b1; in_Mul = mul; in_Acc_en = acc_en; in_Set_cond = s; in_Opcode = op;
        in_Rn = rn; in_Op2 = op2; in_Acc = acc; in_Barrel_carry = bc;
        in_Flag_we = fwe; in_Flag_wdata = fwd;
        waits = 0;
        a = 1'b0;
        while (!a && waits < 200) begin
            waits++;
            cycle(a);
        end
        if (!a) chk("accept_timeout", 64'(a), 64'd1);
        in_Valid = 1'b0; in_Mul = 1'b0; in_Flag_we = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w, n;
        bit a;
        rst_n = 1'b0; in_Valid = 1'b0; in_Ready = 1'b1; in_Rn = '0; in_Op2 = '0; in_Acc = '0;
        in_Barrel_carry = 1'b0; in_Opcode = '0; in_Mul = 1'b0; in_Acc_en = 1'b0;
        in_Set_cond = 1'b0; in_Flag_we = 1'b0; in_Flag_wdata = '0;
        rdy_rand = 1'b0; mflags = '0;
        @(negedge clk); @(negedge clk);
        chk("rst_valid", 64'(out_Valid), 64'd0);
        chk("rst_y", 64'(out_Y), 64'd0);
        chk("rst_wb", 64'(out_Writeback), 64'd0);
        chk("rst_cnzv", 64'(out_CNZV), 64'd0);
        chk("rst_busy", 64'(out_Busy), 64'd0);
        chk("rst_ready", 64'(out_Ready), 64'd1);
        rst_n = 1'b1;
        @(negedge clk);

        issue(1'b0, 1'b0, 1'b1, 4'h2, 32'd5, 32'd7, 32'd0, 1'b0, 1'b0, 4'h0, w);
        chk("subs_5_7_y", 64'(out_Y), 64'hFFFF_FFFE);
        chk("subs_5_7_cnzv", 64'(out_CNZV), 64'b0100);
        chk("subs_valid", 64'(out_Valid), 64'd1);
        issue(1'b0, 1'b0, 1'b1, 4'h2, 32'd7, 32'd5, 32'd0, 1'b0, 1'b0, 4'h0, w);
        chk("subs_7_5_y", 64'(out_Y), 64'd2);
        chk("subs_7_5_cnzv", 64'(out_CNZV), 64'b1000);

        issue(1'b0, 1'b0, 1'b1, 4'h4, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 4'h0, w);
        chk("adds_ovf_y", 64'(out_Y), 64'h8000_0000);
        chk("adds_ovf_cnzv", 64'(out_CNZV), 64'b0101);
        issue(1'b0, 1'b0, 1'b0, 4'h5, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 4'h0, w);
        chk("adc_c0_y", 64'(out_Y), 64'd0);
        chk("adc_nos_cnzv", 64'(out_CNZV), 64'b0101);

        issue(1'b0, 1'b0, 1'b1, 4'h4, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 1'b0, 4'h0, w);
        chk("adds_carry_cnzv", 64'(out_CNZV), 64'b1010);
        issue(1'b0, 1'b0, 1'b0, 4'h5, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 4'h0, w);
        chk("b2b_accept_wait", 64'(w), 64'd1);
        chk("adc_fwd_y", 64'(out_Y), 64'd3);

        issue(1'b1, 1'b1, 1'b1, 4'h0, 32'd3, 32'd5, 32'd2, 1'b0, 1'b0, 4'h0, w);
        chk("mla_busy", 64'(out_Busy), 64'd1);
        n = 0;
        while (!out_Ready && n < 100) begin
            n++;
            cycle(a);
        end
        chk("mla_ready_low_cycles", 64'(n), 64'd16);
        chk("mla_y", 64'(out_Y), 64'd17);
        chk("mla_cnzv", 64'(out_CNZV), 64'b1000);
        chk("mla_valid", 64'(out_Valid), 64'd1);
        chk("mla_not_busy", 64'(out_Busy), 64'd0);

        issue(1'b0, 1'b0, 1'b1, 4'h0, 32'h0F, 32'hF0, 32'd0, 1'b0, 1'b1, 4'hF, w);
        chk("ands_vs_flagwe_cnzv", 64'(out_CNZV), 64'b0010);
        chk("ands_y", 64'(out_Y), 64'd0);
        issue(1'b0, 1'b0, 1'b0, 4'h0, 32'h0F, 32'hF0, 32'd0, 1'b0, 1'b1, 4'hF, w);
        chk("flagwe_only_cnzv", 64'(out_CNZV), 64'hF);
        issue(1'b0, 1'b0, 1'b1, 4'hA, 32'd1, 32'd1, 32'd0, 1'b0, 1'b0, 4'h0, w);
        chk("cmp_wb", 64'(out_Writeback), 64'd0);
        chk("cmp_cnzv", 64'(out_CNZV), 64'b1010);

        issue(1'b1, 1'b0, 1'b1, 4'h0, 32'd7, 32'd9, 32'd0, 1'b0, 1'b0, 4'h0, w);
        cycle(a); cycle(a); cycle(a);
        rst_n = 1'b0;
        #1;
        chk("midmul_rst_busy", 64'(out_Busy), 64'd0);
        chk("midmul_rst_valid", 64'(out_Valid), 64'd0);
        chk("midmul_rst_cnzv", 64'(out_CNZV), 64'd0);
        chk("midmul_rst_y", 64'(out_Y), 64'd0);
        expq.delete();
        mflags = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 64'(out_Ready), 64'd1);
        chk("post_rst_busy", 64'(out_Busy), 64'd0);

        rdy_rand = 1'b1;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                cycle(a);
            end else begin
                issue(1'($urandom_range(0, 4) == 0), 1'($urandom_range(0, 1)),
                      1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                      $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 15)),
                      $urandom_range(0, 1) ? $urandom : 32'($urandom_range(0, 15)),
                      $urandom, 1'($urandom_range(0, 1)), 1'b0, 4'h0, w);
            end
        end
        rdy_rand = 1'b0;
        in_Ready = 1'b1;
        n = 0;
        while ((expq.size() > 0 || out_Valid) && n < 200) begin
            n++;
            cycle(a);
        end
        chk("drain_empty", 64'(expq.size()), 64'd0);
        chk("final_flags", 64'(out_CNZV), 64'(mflags));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, registered successor to the combinational data-processing ALU. Executes all 16 ARM data-processing opcodes and MUL/MLA.
- Owns the CNZV flag register internally, with valid/ready handshakes on both sides.
- Sits between operand fetch/barrel shifter and writeback in the execute stage.
- Data ops: 1-cycle latency. Multiply: iterative, WIDTH/MUL_BITS cycles.

Parameters:
- WIDTH, 32, datapath width in bits (≥8, even).
- MUL_BITS, 2, multiplier bits retired per multiply iteration; must divide WIDTH.

Ports:
- in_Clk  input  1  clock, rising edge.
- in_Rst_n  input  1  asynchronous active-low reset.
- in_Valid  input  1  operation presented.
- out_Ready  output  1  block can accept an operation this cycle.
- in_Rn  input  WIDTH  operand 1.
- in_Op2  input  WIDTH  shifted register or immediate.
- in_Acc  input  WIDTH  MLA accumuland.
- in_Barrel_carry  input  1  shifter carry-out.
- in_Opcode  input  4  ARM data-processing opcode (AND=0 … MVN=F).
- in_Mul  input  1  1 selects multiply; opcode ignored.
- in_Acc_en  input  1  with in_Mul, selects MLA.
- in_Set_cond  input  1  S bit.
- in_Flag_we  input  1  external flag write (MSR).
- in_Flag_wdata  input  4  value for external flag write.
- out_Valid  output  1  result held.
- in_Ready  input  1  consumer takes result.
- out_Y  output  WIDTH  result.
- out_Writeback  output  1  result is to be written to Rd.
- out_CNZV  output  4  flag register: [3]=C, [2]=N, [1]=Z, [0]=V.
- out_Busy  output  1  multiply in progress.

Behaviour:
- States: EMPTY, MUL, FULL. Reset: state=EMPTY, out_Valid=0, out_Y=0, out_Writeback=0, out_CNZV=0, out_Busy=0, iteration count=0.
- out_Ready = (EMPTY) | (FULL & in_Ready). Accept = in_Valid & out_Ready.
- Data op accepted: result and writeback registered at that edge, state→FULL; out_Valid high the next cycle.
- Multiply accepted: operands captured, count=0, state→MUL, out_Busy=1.
- MUL state: each cycle adds the next MUL_BITS multiplier slices of partial product. After WIDTH/MUL_BITS cycles, state→FULL and out_Y = low WIDTH bits of Rn*Op2 (+Acc if in_Acc_en).
- MUL ignores in_Valid; out_Ready=0 throughout.
- FULL & in_Ready & no accept → EMPTY. FULL & in_Ready & accept → back-to-back: new result replaces old, or state→MUL.
- Flags use the value held at acceptance. The ADC/SBC/RSC carry-in is the flag C, not in_Barrel_carry. A dependent op accepted the cycle after an S-op sees the updated flags.
- Arithmetic:
  - SUB/CMP = Rn+~Op2+1; RSB = Op2+~Rn+1.
  - SBC = Rn+~Op2+C; RSC = Op2+~Rn+C; ADC = Rn+Op2+C.
  - C = carry-out of the WIDTH+1-bit sum (1 = no borrow).
  - V = signed overflow of the actual addends.
  - N = MSB; Z = (Y==0).
- Logical ops (AND/EOR/TST/TEQ/ORR/MOV/BIC/MVN): C=in_Barrel_carry, N, Z updated; V unchanged.
- Multiply with S: N, Z updated; C, V unchanged.
- Flags update only when S=1, on the edge the result enters FULL (data: acceptance edge; multiply: final iteration edge).
- out_Writeback=0 for TST/TEQ/CMP/CMN; 1 otherwise, including multiply.
- in_Flag_we writes the flags on any edge. If an S-update occurs on the same edge, the S-update wins.
- Reset asserted mid-multiply: abandons the multiply, all outputs return to reset values immediately.
- Unsigned wrap is modular at WIDTH bits; no saturation.

Decomposition:
- Shared package/defines: opcode constants (reuse existing ALUType definitions), flag bit indices, state encoding.
- One natural sub-module: alu_mul_iter. It holds the iterative shift-add multiplier (start, done, operands, product) so the FSM and flags logic stay in alu_pipe.
- The add/sub path is an inline WIDTH+1-bit add with operand inversion; no separate adder instance.

Test Plan:
- Reset: assert in_Rst_n=0 mid-MUL → out_Valid=0, out_Busy=0, out_CNZV=0, out_Ready=1 next cycle after release.
- SUBS 5−7 (WIDTH=32) → Y=0xFFFFFFFE, CNZV=0b0100. Then SUBS 7−5 → Y=2, C=1, N=0, Z=0, V=0.
- ADDS 0x7FFFFFFF+1 → Y=0x80000000, V=1, N=1, C=0. Following ADC 0+0 with flag C=0 → 0.
- ADDS 0xFFFFFFFF+1 (C=1), next-cycle ADC 1+1 → Y=3, proving flag forwarding with back-to-back accepts at in_Ready=1.
- MLAS Rn=3, Op2=5, Acc=2, MUL_BITS=2 → out_Ready=0 for 16 cycles, then Y=17, N=0, Z=0, C/V unchanged. Random backpressure (in_Ready toggling) → no result lost or duplicated.
- Simultaneous in_Flag_we=1 (wdata=0xF) with accept of ANDS 0x0F&0xF0 (barrel carry 0) → CNZV=0b0010 (Z set); without S → CNZV=0xF. CMP → out_Writeback=0.
